// File: rtl/tag_rx_ctrl_mc.sv
// tag_rx_ctrl_mc: multi-channel I/Q receive controller with sync-window FSM.
// Front-panel GPIO is synchronised (2 flops) and drives an IDLE/SYNC/RX/HOLD
// FSM. SYNC counts a window of SYNC_SIG_N samples; RX forwards the latched
// channel's I/Q one cycle after each in_valid. HOLD blanks output for GUARD_N
// cycles after a channel change.
// Optional feature macro: TAG_RX_MC_DC_REMOVE_EN (DC offset measured during
// SYNC, subtracted with saturation in RX).
// Ports:
//   clk, reset        : clock, async active-high reset
//   in_valid          : sample strobe
//   irx_in, qrx_in    : packed per-channel I/Q samples
//   fp_gpio_in        : bit2 RX_EN, bit6 SYNC_REQ, bits[9:8] channel select
//   fp_gpio_out       : bit10 sync_done, bit11 rx_valid
//   fp_gpio_ddr       : constant direction mask
//   rx_valid          : irx_out/qrx_out valid this cycle
//   irx_out, qrx_out  : selected-channel output samples
//   rx_state          : 0 IDLE, 1 SYNC, 2 RX, 3 HOLD
//   counter_sync      : sample counter
module tag_rx_ctrl_mc #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned GPIO_REG_WIDTH = 12,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_SIG_N     = 8192,
    parameter int unsigned GUARD_N        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   irx_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   qrx_in,
    input  logic [GPIO_REG_WIDTH-1:0]      fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0]      fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0]      fp_gpio_ddr,
    output logic                           rx_valid,
    output logic [DATA_WIDTH-1:0]          irx_out,
    output logic [DATA_WIDTH-1:0]          qrx_out,
    output logic [1:0]                     rx_state,
    output logic [DATA_WIDTH-1:0]          counter_sync
);

    localparam int unsigned CH_W    = 2;
    localparam int unsigned GUARD_W = $clog2(GUARD_N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RX   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             ctl_s1_q, ctl_s2_q;
    logic                   rx_en, sync_req;
    logic [CH_W-1:0]        sel_raw, ch_sel;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [GUARD_W-1:0]     guard_q, guard_d;
    logic [DATA_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   sync_done_q, sync_done_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]  irx_q, irx_d, qrx_q, qrx_d;
    logic                   enter_sync, enter_rx, sync_step, rx_step, wrap;
    logic [DATA_WIDTH-1:0]  rx_i, rx_q, samp_i, samp_q;
    logic                   unused_gpio;

    // Extract one channel from a packed sample bus
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [NUM_CH*DATA_WIDTH-1:0] bus,
                                                   input logic [CH_W-1:0] ch);
        pick = bus[DATA_WIDTH-1:0];
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ch == CH_W'(k)) pick = bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    assign unused_gpio = ^{fp_gpio_in[GPIO_REG_WIDTH-1:10], fp_gpio_in[7],
                           fp_gpio_in[5:3], fp_gpio_in[1:0]};

    // Two-flop synchroniser on the control bits only: {sel[1:0], SYNC_REQ, RX_EN}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_s1_q <= '0;
            ctl_s2_q <= '0;
        end else begin
            ctl_s1_q <= {fp_gpio_in[9:8], fp_gpio_in[6], fp_gpio_in[2]};
            ctl_s2_q <= ctl_s1_q;
        end
    end

    assign rx_en    = ctl_s2_q[0];
    assign sync_req = ctl_s2_q[1];
    assign sel_raw  = ctl_s2_q[3:2];
    assign ch_sel   = (32'(sel_raw) >= NUM_CH) ? '0 : sel_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: !RX_EN beats SYNC_REQ beats channel change
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_en && sync_req)         state_d = ST_SYNC;
                else if (rx_en && sync_done_q) state_d = ST_RX;
            end
            ST_SYNC: begin
                if (!rx_en)         state_d = ST_IDLE;
                else if (!sync_req) state_d = sync_done_q ? ST_RX : ST_IDLE;
            end
            ST_RX: begin
                if (!rx_en)              state_d = ST_IDLE;
                else if (sync_req)       state_d = ST_SYNC;
                else if (ch_sel != ch_q) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!rx_en)                                state_d = ST_IDLE;
                else if (sync_req)                         state_d = ST_SYNC;
                else if (guard_q == GUARD_W'(GUARD_N - 1)) state_d = ST_RX;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_sync = (state_d == ST_SYNC) && (state_q != ST_SYNC);
    assign enter_rx   = (state_d == ST_RX) && (state_q != ST_RX);
    assign sync_step  = (state_q == ST_SYNC) && (state_d == ST_SYNC) && in_valid;
    assign rx_step    = (state_q == ST_RX) && (state_d == ST_RX) && in_valid;
    assign wrap       = (cnt_q == DATA_WIDTH'(SYNC_SIG_N - 1));
    assign rx_i       = pick(irx_in, ch_q);
    assign rx_q       = pick(qrx_in, ch_q);

`ifdef TAG_RX_MC_DC_REMOVE_EN
    localparam int unsigned LOG2N = $clog2(SYNC_SIG_N);
    localparam int unsigned ACC_W = DATA_WIDTH + LOG2N;

    logic signed [ACC_W-1:0]      acc_i_q, acc_i_d, acc_q_q, acc_q_d, sum_i, sum_q;
    logic        [DATA_WIDTH-1:0] off_i_q, off_i_d, off_q_q, off_q_d, sy_i, sy_q;

    // Saturating a - b in DATA_WIDTH two's complement
    function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] d;
        d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (d[DATA_WIDTH] != d[DATA_WIDTH-1])
            sat_sub = d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            sat_sub = d[DATA_WIDTH-1:0];
    endfunction

    assign sy_i  = pick(irx_in, ch_sel);
    assign sy_q  = pick(qrx_in, ch_sel);
    assign sum_i = acc_i_q + {{LOG2N{sy_i[DATA_WIDTH-1]}}, sy_i};
    assign sum_q = acc_q_q + {{LOG2N{sy_q[DATA_WIDTH-1]}}, sy_q};

    // Window accumulation; the wrap sample closes the window and sets the offset
    always_comb begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        off_i_d = off_i_q;
        off_q_d = off_q_q;
        if (enter_sync) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (sync_step) begin
            if (wrap) begin
                acc_i_d = '0;
                acc_q_d = '0;
                off_i_d = DATA_WIDTH'(sum_i >>> LOG2N);
                off_q_d = DATA_WIDTH'(sum_q >>> LOG2N);
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            off_i_q <= '0;
            off_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            off_i_q <= off_i_d;
            off_q_q <= off_q_d;
        end
    end

    assign samp_i = sat_sub(rx_i, off_i_q);
    assign samp_q = sat_sub(rx_q, off_q_q);
`else
    assign samp_i = rx_i;
    assign samp_q = rx_q;
`endif

    // Counter, sync flag, guard, channel latch and output datapath
    always_comb begin
        cnt_d       = cnt_q;
        sync_done_d = sync_done_q;
        guard_d     = '0;
        ch_d        = ch_q;
        rx_valid_d  = rx_step;
        irx_d       = irx_q;
        qrx_d       = qrx_q;

        if ((state_d == ST_IDLE) || enter_sync || enter_rx)
            cnt_d = '0;
        else if (sync_step || rx_step)
            cnt_d = wrap ? '0 : cnt_q + DATA_WIDTH'(1);

        if (enter_sync)              sync_done_d = 1'b0;
        else if (sync_step && wrap)  sync_done_d = 1'b1;

        if ((state_q == ST_HOLD) && (state_d == ST_HOLD))
            guard_d = guard_q + GUARD_W'(1);

        if (enter_rx) ch_d = ch_sel;

        // Outputs are forced to zero whenever the next state is not RX
        if (state_d != ST_RX) begin
            irx_d = '0;
            qrx_d = '0;
        end else if (rx_step) begin
            irx_d = samp_i;
            qrx_d = samp_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            sync_done_q <= 1'b0;
            guard_q     <= '0;
            ch_q        <= '0;
            rx_valid_q  <= 1'b0;
            irx_q       <= '0;
            qrx_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sync_done_q <= sync_done_d;
            guard_q     <= guard_d;
            ch_q        <= ch_d;
            rx_valid_q  <= rx_valid_d;
            irx_q       <= irx_d;
            qrx_q       <= qrx_d;
        end
    end

    always_comb begin
        fp_gpio_out     = '0;
        fp_gpio_out[10] = sync_done_q;
        fp_gpio_out[11] = rx_valid_q;
    end

    assign fp_gpio_ddr  = GPIO_REG_WIDTH'(12'hC00);
    assign rx_valid     = rx_valid_q;
    assign irx_out      = irx_q;
    assign qrx_out      = qrx_q;
    assign rx_state     = state_q;
    assign counter_sync = cnt_q;

endmodule

// File: tb/tb_tag_rx_ctrl_mc.sv
// Self-checking bench for tag_rx_ctrl_mc: directed GPIO scenarios with
// randomized sample data; a reference model predicts each RX output from the
// sample driven one cycle earlier on the expected channel.
module tb_tag_rx_ctrl_mc;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int GW  = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [NCH*DW-1:0]  irx_in, qrx_in;
    logic [GW-1:0]      fp_gpio_in;
    logic [GW-1:0]      fp_gpio_out, fp_gpio_ddr;
    logic               rx_valid;
    logic [DW-1:0]      irx_out, qrx_out;
    logic [1:0]         rx_state;
    logic [DW-1:0]      counter_sync;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard / model state
    bit sb_en     = 1'b0;
    int sb_ch     = 0;
    bit rand_mode = 1'b0;
    int off_i     = 0;
    int off_q     = 0;

    tag_rx_ctrl_mc dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .irx_in       (irx_in),
        .qrx_in       (qrx_in),
        .fp_gpio_in   (fp_gpio_in),
        .fp_gpio_out  (fp_gpio_out),
        .fp_gpio_ddr  (fp_gpio_ddr),
        .rx_valid     (rx_valid),
        .irx_out      (irx_out),
        .qrx_out      (qrx_out),
        .rx_state     (rx_state),
        .counter_sync (counter_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int samp(input logic [NCH*DW-1:0] bus, input int ch);
        logic signed [DW-1:0] s;
        s = bus[ch*DW +: DW];
        return int'(s);
    endfunction

    // Expected output: sample minus offset, clamped to the signed range
    function automatic int exp_out(input int s, input int o);
        int d;
        d = s - o;
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    function automatic logic [DW-1:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    // One clock: inputs held across the rising edge, outputs checked at the falling edge
    task automatic cyc();
        logic [NCH*DW-1:0] pi, pq;
        pi = irx_in;
        pq = qrx_in;
        @(negedge clk);
        if (sb_en && rx_valid) begin
            check("rx_i_data", $signed(irx_out), exp_out(samp(pi, sb_ch), off_i));
            check("rx_q_data", $signed(qrx_out), exp_out(samp(pq, sb_ch), off_q));
        end
        if (rand_mode) begin
            irx_in = {rnd16(), rnd16(), rnd16(), rnd16()};
            qrx_in = {rnd16(), rnd16(), rnd16(), rnd16()};
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int hold;

        reset      = 1'b1;
        in_valid   = 1'b0;
        irx_in     = '0;
        qrx_in     = '0;
        fp_gpio_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state",   rx_state, 0);
        check("rst_valid",   rx_valid, 0);
        check("rst_irx",     irx_out, 0);
        check("rst_qrx",     qrx_out, 0);
        check("rst_counter", counter_sync, 0);
        check("rst_gpio_out", fp_gpio_out, 0);
        check("rst_gpio_ddr", fp_gpio_ddr, 32'hC00);
        reset = 1'b0;

        // Aborted sync: no sync_done, RX must stay unreachable
        in_valid   = 1'b1;
        rand_mode  = 1'b1;
        fp_gpio_in = 12'h044;
        repeat (2) cyc();
        check("sync_lat_early", rx_state, 0);
        cyc();
        check("sync_lat", rx_state, 1);
        repeat (997) cyc();
        check("abort_cnt_997", counter_sync, 997);
        fp_gpio_in = 12'h000;
        repeat (3) cyc();
        check("abort_state", rx_state, 0);
        check("abort_cnt", counter_sync, 0);
        fp_gpio_in = 12'h004;
        bad = 1'b0;
        repeat (40) begin
            cyc();
            if (rx_state != 2'd0 || rx_valid) bad = 1'b1;
        end
        check("abort_no_rx", bad, 0);
        check("abort_gpio_out", fp_gpio_out, 0);

        // Full sync window on constant ch0 data
        rand_mode  = 1'b0;
        irx_in     = {rnd16(), rnd16(), rnd16(), 16'h3E80};
        qrx_in     = {rnd16(), rnd16(), rnd16(), 16'hC180};
        fp_gpio_in = 12'h044;
        repeat (3) cyc();
        check("sync_state", rx_state, 1);
        check("sync_cnt0", counter_sync, 0);
        repeat (8191) cyc();
        check("sync_cnt_max", counter_sync, 8191);
        check("sync_done_pre", fp_gpio_out, 0);
        cyc();
        check("sync_cnt_wrap", counter_sync, 0);
        check("sync_done", fp_gpio_out, 32'h400);
`ifdef TAG_RX_MC_DC_REMOVE_EN
        off_i = 16000;
        off_q = -16000;
`endif

        // Enter RX on channel 0
        fp_gpio_in = 12'h004;
        repeat (3) cyc();
        check("rx_state", rx_state, 2);
        check("rx_entry_valid", rx_valid, 0);
        check("rx_entry_cnt", counter_sync, 0);
        cyc();
        check("rx_first_valid", rx_valid, 1);
        check("rx_first_i", $signed(irx_out), exp_out(16000, off_i));
        check("rx_first_q", $signed(qrx_out), exp_out(-16000, off_q));
        check("rx_gpio_out", fp_gpio_out, 32'hC00);
        irx_in[DW-1:0] = 16'h8000;
        qrx_in[DW-1:0] = 16'h7FFF;
        cyc();
        check("rx_sat_i", $signed(irx_out), -32768);
        check("rx_sat_q", $signed(qrx_out), 32767);
        sb_en     = 1'b1;
        rand_mode = 1'b1;
        repeat (200) cyc();
        check("rx_cnt", counter_sync, 202);

        // Channel switch with guard blanking
        fp_gpio_in = 12'h104;
        repeat (2) cyc();
        check("chsw_lat_early", rx_state, 2);
        cyc();
        check("hold_state", rx_state, 3);
        check("hold_valid", rx_valid, 0);
        check("hold_irx_zero", irx_out, 0);
        sb_ch = 1;
        hold  = 1;
        bad   = 1'b0;
        for (int i = 0; i < 100 && rx_state == 2'd3; i++) begin
            cyc();
            if (rx_state == 2'd3) begin
                hold++;
                if (rx_valid) bad = 1'b1;
            end
        end
        check("hold_len", hold, 16);
        check("hold_no_valid", bad, 0);
        check("hold_exit_state", rx_state, 2);
        check("hold_exit_valid", rx_valid, 0);
        repeat (50) cyc();
        check("ch1_valid", rx_valid, 1);
        check("ch1_cnt", counter_sync, 50);

        // RX_EN drop returns to IDLE three cycles later
        fp_gpio_in = 12'h000;
        repeat (2) cyc();
        check("dis_lat_early", rx_state, 2);
        cyc();
        check("dis_state", rx_state, 0);
        check("dis_valid", rx_valid, 0);
        check("dis_irx", irx_out, 0);
        check("dis_cnt", counter_sync, 0);
        check("dis_sync_kept", fp_gpio_out, 32'h400);
        sb_en = 1'b0;

        // IDLE -> RX using the retained sync_done
        fp_gpio_in = 12'h004;
        repeat (3) cyc();
        check("reenter_rx", rx_state, 2);

        // SYNC_REQ wins over a simultaneous channel change
        fp_gpio_in = 12'h144;
        repeat (3) cyc();
        check("prio_sync", rx_state, 1);
        check("prio_sync_done_clr", fp_gpio_out, 0);
        check("prio_cnt", counter_sync, 0);
        repeat (100) cyc();
        check("midsync_cnt", counter_sync, 100);

        // Asynchronous reset mid-SYNC
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_state", rx_state, 0);
        check("arst_cnt", counter_sync, 0);
        check("arst_gpio_out", fp_gpio_out, 0);
        check("arst_irx", irx_out, 0);
        fp_gpio_in = 12'h004;
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (30) begin
            cyc();
            if (rx_state != 2'd0 || rx_valid) bad = 1'b1;
        end
        check("arst_no_rx", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
